// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and waveform helper for the audio tone generator
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  typedef enum logic [1:0] {
    WAVE_SQ  = 2'd0,
    WAVE_SAW = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_OFF = 2'd3
  } wave_t;

  localparam int ENV_MAX = 256;
  localparam int AUDIO_W = 24;

  // Full-scale 16-bit signed waveform from the top 16 phase bits.
  function automatic logic signed [15:0] raw_wave(input logic [1:0] sel, input logic [15:0] p);
    logic [15:0] r;
    r = 16'h0000;
    case (sel)
      WAVE_SQ:  r = p[15] ? 16'h8000 : 16'h7FFF;
      WAVE_SAW: r = p ^ 16'h8000;
      WAVE_TRI: r = p[15] ? ({~p[14:0], 1'b0} ^ 16'h8000) : ({p[14:0], 1'b0} ^ 16'h8000);
      default:  r = 16'h0000;
    endcase
    return $signed(r);
  endfunction

endpackage

// File: rtl/lrclk_tick_sync.sv
// rtl/lrclk_tick_sync.sv - LRCLK synchroniser with one-cycle falling-edge tick
module lrclk_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic lrclk,
  output logic tick
);

  logic sync_a, sync_b, hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      hist   <= 1'b0;
    end else begin
      sync_a <= lrclk;
      sync_b <= sync_a;
      hist   <= sync_b;
    end
  end

  assign tick = hist & ~sync_b;

endmodule

// File: rtl/audio_tone_gen.sv
// rtl/audio_tone_gen.sv - per-frame oscillator with attack/sustain/release envelope
module audio_tone_gen
  import audio_pkg::*;
#(
  parameter int PHASE_W      = 16,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               LRCLK,
  input  logic               AUDIO_EN,
  input  logic               note_on,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  input  logic [2:0]         atten,
  output logic [AUDIO_W-1:0] AUDIO_L,
  output logic [AUDIO_W-1:0] AUDIO_R,
  output logic               sample_valid,
  output logic [1:0]         env_state
);

  localparam logic [9:0] ATK  = 10'(ATTACK_STEP);
  localparam logic [8:0] REL  = 9'(RELEASE_STEP);
  localparam logic [8:0] EMAX = 9'(ENV_MAX);

  logic tick;

  lrclk_tick_sync u_sync (
    .clk   (Clk),
    .rst_n (Reset_n),
    .lrclk (LRCLK),
    .tick  (tick)
  );

  env_state_t          st_q, st_d;
  logic [8:0]          env_q, env_d, env_up, env_dn;
  logic [9:0]          env_sum;
  logic [PHASE_W-1:0]  phase_q, phase_base;
  logic                clr_phase;
  logic signed [15:0]  raw_q, raw_d, s16, s;
  logic [2:0]          atten_q;
  logic                stage_v;
  logic signed [24:0]  prod;
  logic [AUDIO_W-1:0]  audio_q;

  always_comb begin
    env_sum = {1'b0, env_q} + ATK;
    env_up  = (env_sum >= {1'b0, EMAX}) ? EMAX : env_sum[8:0];
    env_dn  = (env_q <= REL) ? 9'd0 : env_q - REL;
  end

  // A held key always climbs (SUSTAIN just stays pinned at the top);
  // a released key always falls, so release wins over saturation.
  always_comb begin
    st_d      = st_q;
    env_d     = env_q;
    clr_phase = 1'b0;
    if (note_on) begin
      env_d     = env_up;
      st_d      = (env_up == EMAX) ? SUSTAIN : ATTACK;
      clr_phase = (st_q == IDLE);
    end else if (st_q != IDLE) begin
      env_d = env_dn;
      st_d  = (env_dn == 9'd0) ? IDLE : RELEASE;
    end
  end

  assign phase_base = clr_phase ? '0 : phase_q;
  assign raw_d      = raw_wave(wave_sel, phase_base[PHASE_W-1 -: 16]);

  assign prod = $signed({{9{raw_q[15]}}, raw_q}) * $signed({16'd0, env_q});
  assign s16  = 16'(prod >>> 8);
  assign s    = s16 >>> atten_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q         <= IDLE;
      env_q        <= 9'd0;
      phase_q      <= '0;
      raw_q        <= 16'sd0;
      atten_q      <= 3'd0;
      stage_v      <= 1'b0;
      sample_valid <= 1'b0;
      audio_q      <= '0;
    end else if (!AUDIO_EN) begin
      st_q         <= IDLE;
      env_q        <= 9'd0;
      phase_q      <= '0;
      raw_q        <= 16'sd0;
      atten_q      <= 3'd0;
      stage_v      <= 1'b0;
      sample_valid <= 1'b0;
      audio_q      <= '0;
    end else begin
      stage_v      <= tick;
      sample_valid <= stage_v;
      if (tick) begin
        st_q    <= st_d;
        env_q   <= env_d;
        phase_q <= phase_base + phase_inc;
        raw_q   <= raw_d;
        atten_q <= atten;
      end
      if (stage_v) begin
        audio_q <= {s, 8'h00};
      end
    end
  end

  assign AUDIO_L   = audio_q;
  assign AUDIO_R   = audio_q;
  assign env_state = st_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// tb/tb_audio_tone_gen.sv - self-checking bench for audio_tone_gen
module tb_audio_tone_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lrclk = 1'b0;
  logic        en = 1'b1;
  logic        note_on = 1'b0;
  logic [15:0] phase_inc = 16'h0800;
  logic [1:0]  wave_sel = 2'd0;
  logic [2:0]  atten = 3'd0;
  logic [23:0] audio_l, audio_r;
  logic        sample_valid;
  logic [1:0]  env_state;

  audio_tone_gen #(.PHASE_W(16), .ATTACK_STEP(8), .RELEASE_STEP(4)) dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .LRCLK        (lrclk),
    .AUDIO_EN     (en),
    .note_on      (note_on),
    .phase_inc    (phase_inc),
    .wave_sel     (wave_sel),
    .atten        (atten),
    .AUDIO_L      (audio_l),
    .AUDIO_R      (audio_r),
    .sample_valid (sample_valid),
    .env_state    (env_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] val;
    int          st;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [23:0] last_val = 24'h0;
  int          menv = 0;
  int          mst = 0;
  int          mphase = 0;
  logic [23:0] saw_exp [4] = '{24'h800000, 24'hC00000, 24'h000000, 24'h400000};

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int raw_of(input int sel, input int p);
    case (sel)
      0:       return (p < 32768) ? 32767 : -32768;
      1:       return p - 32768;
      2:       return (p < 32768) ? (2 * p - 32768) : (2 * (65535 - p) - 32768);
      default: return 0;
    endcase
  endfunction

  // Envelope and oscillator rules applied once per LRCLK fall.
  task automatic model_tick();
    int   raw, smp;
    exp_t e;
    if (!en || !rst_n) return;
    if (note_on) begin
      if (mst == 0) mphase = 0;
      menv = (menv + 8 > 256) ? 256 : menv + 8;
      mst  = (menv == 256) ? 2 : 1;
    end else if (mst != 0) begin
      menv = (menv < 4) ? 0 : menv - 4;
      mst  = (menv == 0) ? 0 : 3;
    end
    raw    = raw_of(int'(wave_sel), mphase);
    smp    = floor_div(floor_div(raw * menv, 256), 1 << atten);
    mphase = (mphase + int'(phase_inc)) % 65536;
    e.due  = cyc + 4;
    e.val  = 24'(smp * 256);
    e.st   = mst;
    q.push_back(e);
  endtask

  task automatic model_clear();
    q.delete();
    last_val = 24'h0;
    menv     = 0;
    mst      = 0;
    mphase   = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk(sample_valid === 1'b1, "valid_pulse", 32'(sample_valid), 1);
      chk(audio_l === q[0].val, "audio_l", audio_l, q[0].val);
      chk(audio_r === q[0].val, "audio_r", audio_r, q[0].val);
      chk(env_state === 2'(q[0].st), "env_state", env_state, q[0].st);
      last_val = q[0].val;
      void'(q.pop_front());
    end else begin
      chk(sample_valid === 1'b0, "valid_quiet", 32'(sample_valid), 0);
      chk(audio_l === last_val && audio_r === last_val, "hold", audio_l, last_val);
    end
  end

  task automatic frame();
    lrclk = 1'b1;
    repeat (8) @(negedge clk);
    lrclk = 1'b0;
    model_tick();
    repeat (8) @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [23:0] v, input logic [1:0] st);
    chk(audio_l === v, name, audio_l, v);
    chk(env_state === st, name, env_state, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    repeat (3) frame();
    pin("reset_state", 24'h0, 2'd0);
    rst_n = 1'b1;

    note_on = 1'b1;
    frame();
    pin("attack_1", 24'h03FF00, 2'd1);
    repeat (30) frame();
    pin("attack_31", 24'h840000, 2'd1);
    frame();
    pin("sustain_32", 24'h800000, 2'd2);

    wave_sel  = 2'd1;
    phase_inc = 16'h4000;
    for (int i = 0; i < 8; i++) begin
      frame();
      chk(audio_l === saw_exp[i % 4], "saw_wrap", audio_l, saw_exp[i % 4]);
    end

    note_on = 1'b0;
    repeat (13) frame();
    chk(env_state === 2'd3, "release_state", env_state, 3);
    frame();
    pin("release_200", 24'hCE0000, 2'd3);

    note_on = 1'b1;
    repeat (6) frame();
    chk(env_state === 2'd1, "reattack_state", env_state, 1);
    frame();
    pin("reattack_256", 24'h800000, 2'd2);

    wave_sel = 2'd0;
    atten    = 3'd3;
    frame();
    pin("atten_pos", 24'h0FFF00, 2'd2);
    frame();
    pin("atten_neg", 24'hF00000, 2'd2);

    wave_sel = 2'd2;
    atten    = 3'd0;
    frame();
    pin("tri_neg", 24'hFFFE00, 2'd2);
    wave_sel = 2'd3;
    frame();
    pin("silence", 24'h0, 2'd2);
    wave_sel = 2'd2;
    repeat (2) frame();

    wave_sel  = 2'd0;
    phase_inc = 16'h0800;
    en = 1'b0;
    model_clear();
    @(posedge clk);
    #2;
    pin("disable_sustain", 24'h0, 2'd0);
    @(negedge clk);
    en = 1'b1;
    frame();
    pin("reenable_1", 24'h03FF00, 2'd1);
    repeat (2) frame();

    en = 1'b0;
    model_clear();
    @(posedge clk);
    #2;
    pin("disable_attack", 24'h0, 2'd0);
    chk(sample_valid === 1'b0, "disable_valid", 32'(sample_valid), 0);
    @(negedge clk);
    en = 1'b1;
    frame();
    pin("restart_1", 24'h03FF00, 2'd1);

    lrclk = 1'b1;
    repeat (8) @(negedge clk);
    lrclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    repeat (4) @(negedge clk);
    pin("reset_midpipe", 24'h0, 2'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
